// File: rtl/ad_sample_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_sample_packer_pkg
// Description : Shared widths, frame size and packer state encoding for the
//               AD7606 sample packer, plus the word-packing helper.
// Contents    : AD_SAMPLE_W  - width of one channel sample
//               AD_WORD_W    - width of one packed FIFO word
//               AD_NCH       - default channels per conversion frame
//               AD_CH_W      - width of the channel index
//               pack_state_t - packer FSM states (IDLE/LOW/HIGH)
//               pack_word()  - {odd sample, even sample} word builder
// Revision    : 1.0 - initial release
// ============================================================================
package ad_sample_packer_pkg;

  localparam int AD_SAMPLE_W = 16;
  localparam int AD_WORD_W   = 32;
  localparam int AD_NCH      = 8;
  localparam int AD_CH_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // expecting channel 0
    ST_LOW  = 2'd1,  // expecting the next even channel
    ST_HIGH = 2'd2   // even half held, expecting its odd partner
  } pack_state_t;

  // The odd channel lands in the upper half so that a little-endian host
  // reading the word as two 16-bit halves sees the channels in order.
  function automatic logic [AD_WORD_W-1:0] pack_word(
    input logic [AD_SAMPLE_W-1:0] hi,
    input logic [AD_SAMPLE_W-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_sample_packer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with inferred dual-port RAM and a
//               registered (non show-ahead) read port.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               wr_en/wr_data - write request and data
//               rd_en         - read request (ignored while empty)
//               rd_data       - popped word, updated on the read edge
//               rd_valid      - high the cycle after an accepted read
//               usedw         - words stored, 0..2^ADDR_W
//               empty/full    - decoded from usedw
//               wr_drop       - write refused because FIFO was full
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   usedw,
  output logic              empty,
  output logic              full,
  output logic              wr_drop
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_usedw;
  logic [WIDTH-1:0]  r_rd_data;
  logic              r_rd_valid;

  logic w_rd_fire;
  logic w_wr_fire;

  assign empty = (r_usedw == '0);
  assign full  = (r_usedw == C_DEPTH);

  // A read frees a slot on the same edge, so a write into a full FIFO is
  // still accepted when it coincides with a read.
  assign w_rd_fire = rd_en & ~empty;
  assign w_wr_fire = wr_en & (~full | w_rd_fire);
  assign wr_drop   = wr_en & full & ~rd_en;

  // Storage array kept free of reset so it maps onto block RAM. When full
  // with simultaneous read and write, both pointers address the same entry;
  // the read below samples the old contents before this write lands.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_usedw    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_wr_fire) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_fire) begin
        r_rptr    <= r_rptr + 1'b1;
        r_rd_data <= r_mem[r_rptr];
      end
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_usedw <= r_usedw + 1'b1;
        2'b01:   r_usedw <= r_usedw - 1'b1;
        default: r_usedw <= r_usedw;
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign usedw    = r_usedw;

endmodule
`default_nettype wire

// File: rtl/ad_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : ad_sample_packer
// Description : Pairs consecutive 16-bit AD7606 channel samples into 32-bit
//               words and queues them in an on-chip FIFO for the host.
//               Flags channel sequencing errors and FIFO overflow (sticky).
// Ports       : clk, rst      - 50 MHz clock, synchronous active-high reset
//               s_data        - channel sample
//               s_valid       - one-cycle sample strobe
//               s_ch          - channel index of s_data
//               read_data     - host read request, one word per cycle
//               result        - popped word {odd ch, even ch}
//               result_valid  - result updated by the last edge
//               usedw         - words stored, 0..2^ADDR_W
//               empty/full    - FIFO level flags
//               overflow      - sticky: a packed word was dropped
//               seq_err       - sticky: an out-of-order channel arrived
// Revision    : 1.0 - initial release
// ============================================================================
module ad_sample_packer
  import ad_sample_packer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NCH    = AD_NCH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AD_SAMPLE_W-1:0] s_data,
  input  logic                   s_valid,
  input  logic [AD_CH_W-1:0]     s_ch,
  input  logic                   read_data,
  output logic [AD_WORD_W-1:0]   result,
  output logic                   result_valid,
  output logic [ADDR_W:0]        usedw,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   seq_err
);

  localparam logic [AD_CH_W-1:0] C_LAST_CH = AD_CH_W'(NCH - 1);

  pack_state_t              r_state;
  pack_state_t              w_state_nxt;
  // In IDLE/LOW this is the even channel expected next; in HIGH it is the
  // even channel currently held in r_lo.
  logic [AD_CH_W-1:0]       r_exp_ch;
  logic [AD_CH_W-1:0]       w_exp_ch_nxt;
  logic [AD_SAMPLE_W-1:0]   r_lo;
  logic                     r_seq_err;
  logic                     r_overflow;

  logic [AD_CH_W-1:0]       w_want_ch;
  logic                     w_mismatch;
  logic                     w_lo_load;
  logic                     w_wr_en;
  logic                     w_seq_err_set;
  logic                     w_fifo_drop;
  logic [AD_WORD_W-1:0]     w_word;

  // --------------------------------------------------------------------------
  // Packer FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_exp_ch <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_exp_ch <= w_exp_ch_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Packer FSM: next state and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_exp_ch_nxt  = r_exp_ch;
    w_want_ch     = '0;
    w_mismatch    = 1'b0;
    w_lo_load     = 1'b0;
    w_wr_en       = 1'b0;
    w_seq_err_set = 1'b0;

    case (r_state)
      ST_IDLE, ST_LOW: begin
        w_want_ch = (r_state == ST_IDLE) ? '0 : r_exp_ch;
        if (s_valid) begin
          if (s_ch == w_want_ch) begin
            w_lo_load    = 1'b1;
            w_exp_ch_nxt = s_ch;
            w_state_nxt  = ST_HIGH;
          end else begin
            w_mismatch = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        w_want_ch = r_exp_ch + AD_CH_W'(1);
        if (s_valid) begin
          if (s_ch == w_want_ch) begin
            w_wr_en = 1'b1;
            if (s_ch == C_LAST_CH) begin
              w_exp_ch_nxt = '0;
              w_state_nxt  = ST_IDLE;
            end else begin
              w_exp_ch_nxt = r_exp_ch + AD_CH_W'(2);
              w_state_nxt  = ST_LOW;
            end
          end else begin
            w_mismatch = 1'b1;
          end
        end
      end

      default: begin
        w_exp_ch_nxt = '0;
        w_state_nxt  = ST_IDLE;
      end
    endcase

    // Any held half is abandoned. A channel-0 sample is still useful as the
    // start of a new frame, so it is kept rather than thrown away.
    if (w_mismatch) begin
      w_seq_err_set = 1'b1;
      w_exp_ch_nxt  = '0;
      if (s_ch == '0) begin
        w_lo_load   = 1'b1;
        w_state_nxt = ST_HIGH;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Held even half and sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo       <= '0;
      r_seq_err  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_lo_load) begin
        r_lo <= s_data;
      end
      if (w_seq_err_set) begin
        r_seq_err <= 1'b1;
      end
      if (w_fifo_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_word = pack_word(s_data, r_lo);

  // --------------------------------------------------------------------------
  // Word FIFO
  // --------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH  (AD_WORD_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_wr_en),
    .wr_data  (w_word),
    .rd_en    (read_data),
    .rd_data  (result),
    .rd_valid (result_valid),
    .usedw    (usedw),
    .empty    (empty),
    .full     (full),
    .wr_drop  (w_fifo_drop)
  );

  assign seq_err  = r_seq_err;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
